// File: rtl/pxs_frame_router_if.sv
// Pixel stream, routing config and status bundle
// for the frame router.
interface pxs_frame_router_if #(
  parameter int CNT_W = 16
);
  logic [25:0]      RGBStr_i;
  logic [1:0]       cfg_mode_i;
  logic             cfg_alt_i;
  logic [25:0]      RGBStr1_o;
  logic [25:0]      RGBStr2_o;
  logic [1:0]       route_o;
  logic             busy_o;
  logic [CNT_W-1:0] frm_cnt1_o;
  logic [CNT_W-1:0] frm_cnt2_o;

  modport slave (
    input  RGBStr_i,
    input  cfg_mode_i,
    input  cfg_alt_i,
    output RGBStr1_o,
    output RGBStr2_o,
    output route_o,
    output busy_o,
    output frm_cnt1_o,
    output frm_cnt2_o
  );

  modport master (
    output RGBStr_i,
    output cfg_mode_i,
    output cfg_alt_i,
    input  RGBStr1_o,
    input  RGBStr2_o,
    input  route_o,
    input  busy_o,
    input  frm_cnt1_o,
    input  frm_cnt2_o
  );
endinterface

// File: rtl/pxs_frame_router.sv
// Frame-synchronous 1-to-2 pixel stream router
// with optional frame alternation and frame counters.
module pxs_frame_router #(
  parameter int CNT_W = 16
) (
  input logic px_clk,
  input logic rst,
  pxs_frame_router_if.slave bus
);
  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             fval;
  logic             start;
  logic             frm_end;
  logic             pass;
  logic [1:0]       route_dec;
  logic [1:0]       eff_route;
  logic [1:0]       route_q, route_d;
  logic             tog_q, tog_d;
  logic [25:0]      out1_q, out1_d;
  logic [25:0]      out2_q, out2_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [CNT_W-1:0] cnt2_q, cnt2_d;

  assign fval = bus.RGBStr_i[25];

  always_ff @(posedge px_clk) begin
    if (rst) begin
      state_q <= SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SYNC:    if (!fval) state_d = IDLE;
      IDLE:    if (fval)  state_d = ACTIVE;
      ACTIVE:  if (!fval) state_d = IDLE;
      default: state_d = SYNC;
    endcase
  end

  // Route is frozen at frame start; the first
  // word uses the freshly decided route.
  always_comb begin
    start     = (state_q == IDLE) && fval;
    frm_end   = (state_q == ACTIVE) && !fval;
    route_dec = bus.cfg_alt_i
              ? (tog_q ? 2'b10 : 2'b01)
              : bus.cfg_mode_i;
    eff_route = start ? route_dec : route_q;
    pass      = fval &&
                ((state_q == ACTIVE) || start);
    out1_d    = (pass && eff_route[0])
              ? bus.RGBStr_i : 26'b0;
    out2_d    = (pass && eff_route[1])
              ? bus.RGBStr_i : 26'b0;
    route_d   = eff_route;
    tog_d     = (start && bus.cfg_alt_i)
              ? ~tog_q : tog_q;
    cnt1_d    = (frm_end && route_q[0])
              ? cnt1_q + ONE : cnt1_q;
    cnt2_d    = (frm_end && route_q[1])
              ? cnt2_q + ONE : cnt2_q;
  end

  always_ff @(posedge px_clk) begin
    if (rst) begin
      out1_q  <= '0;
      out2_q  <= '0;
      route_q <= '0;
      tog_q   <= 1'b0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
    end else begin
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      route_q <= route_d;
      tog_q   <= tog_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
    end
  end

  assign bus.RGBStr1_o  = out1_q;
  assign bus.RGBStr2_o  = out2_q;
  assign bus.route_o    = route_q;
  assign bus.busy_o     = (state_q == ACTIVE);
  assign bus.frm_cnt1_o = cnt1_q;
  assign bus.frm_cnt2_o = cnt2_q;
endmodule
